camera_bringup_sequencer: RTL and testbench
===========================================

Name: camera_bringup_sequencer

Overview:
- Hardware power-up/link-training sequencer for the PYTHON300 + Spartan-7 MIPI camera path.
- Drives the clock, sensor, LVDS receiver, word-align and D-PHY reset/enable controls in order, waiting on each status input with timeouts.
- On align failure, sweeps the receiver clock delay and retries.
- Sits between the system control register block (start/stop, status readback) and the sensor/receiver/D-PHY datapath.

Parameters:
- TIMER_BITS, 20, width of the shared wait/timeout counter.
- RST_CYCLES, 1000, reset-hold and settle time in cycles (CLK_RST, RX, RETRY); range 1..2^TIMER_BITS-1.
- LOCK_TIMEOUT, 100000, max cycles waiting for in_clk_locked.
- SENSOR_TIMEOUT, 500000, max cycles waiting for in_sensor_ready.
- ALIGN_TIMEOUT, 10000, max cycles per align attempt.
- DPHY_TIMEOUT, 100000, max cycles waiting for in_dphy_init_done.
- CLK_DLY_INIT, 5'd8, receiver clock delay loaded on start.
- CLK_DLY_STEP, 5'd1, delay increment per align retry.
- MAX_RETRY, 8, align attempts allowed before ERROR; range 1..15.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin sequence; level-sampled; honoured only in IDLE or ERROR.
- stop, input, 1, abort/shutdown; highest priority.
- in_clk_locked, input, 1, MMCM/PLL locked.
- in_sensor_ready, input, 1, sensor ready.
- in_align_done, input, 1, word align complete.
- in_align_error, input, 1, word align failure.
- in_dphy_init_done, input, 1, D-PHY init complete.
- out_clk_rst, output, 1, MMCM/PLL reset.
- out_sensor_enable, output, 1, sensor enable.
- out_receiver_reset, output, 1, receiver reset.
- out_receiver_clk_dly, output, 5, receiver clock delay tap.
- out_align_reset, output, 1, aligner reset.
- out_dphy_reset, output, 1, D-PHY core and sys reset.
- busy, output, 1, sequence in progress.
- done, output, 1, link running.
- error, output, 1, sequence failed.
- error_code, output, 3, 1=lock, 2=sensor, 3=align retries exhausted, 4=dphy.
- retry_count, output, 4, align attempts failed in the current sequence.
- state, output, 4, current state encoding, for debug readback.

Behaviour:
- All status inputs are synchronous to clk; synchronisation is the caller's responsibility.
- Reset values:
  - state IDLE; timer 0.
  - out_clk_rst=1, out_sensor_enable=0, out_receiver_reset=1, out_align_reset=1, out_dphy_reset=1.
  - out_receiver_clk_dly=CLK_DLY_INIT.
  - busy=0, done=0, error=0, error_code=0, retry_count=0.
- All outputs are registered. The timer clears on every state entry and increments each cycle in the state. "After N" means the transition occurs when timer==N-1, so the state is held exactly N cycles.
- States (encoding in brackets):
  - IDLE(0): all controls in reset pattern. start -> CLK_RST; retry_count cleared; clk_dly reloaded to CLK_DLY_INIT.
  - CLK_RST(1): out_clk_rst=1, busy=1. After RST_CYCLES -> CLK_LOCK.
  - CLK_LOCK(2): out_clk_rst=0. in_clk_locked -> SENSOR; after LOCK_TIMEOUT -> ERROR, code 1.
  - SENSOR(3): out_sensor_enable=1. in_sensor_ready -> RX; after SENSOR_TIMEOUT -> ERROR, code 2.
  - RX(4): out_receiver_reset=0. After RST_CYCLES -> ALIGN.
  - ALIGN(5): out_align_reset=0. in_align_done && !in_align_error -> DPHY. in_align_error, or ALIGN_TIMEOUT elapsed, -> RETRY. in_align_error wins when it is high together with in_align_done.
  - RETRY(6): on entry, out_align_reset=1, out_receiver_reset=1, retry_count+1, and clk_dly+CLK_DLY_STEP (modulo 32, wraps 31->0). If the incremented retry_count==MAX_RETRY -> ERROR, code 3, immediately. Otherwise hold RST_CYCLES -> RX.
  - DPHY(7): out_dphy_reset=0. in_dphy_init_done -> RUN; after DPHY_TIMEOUT -> ERROR, code 4.
  - RUN(8): busy=0, done=1; all controls held released. A later drop of an input does not change state.
  - ERROR(9): busy=0, error=1; error_code latched. Controls revert to the reset pattern, except out_receiver_clk_dly, which holds its last value for readback. start -> CLK_RST, clearing error/error_code/retry_count and reloading clk_dly.
- stop: any state -> IDLE next cycle; clears done/error/error_code; stop beats start. start while busy is ignored.
- reset mid-sequence restores all reset values next cycle.
- error_code holds until a new start, stop or reset.

Test Plan:
- Params RST_CYCLES=4, timeouts=16, MAX_RETRY=3. Pulse start, with every status input asserted one cycle after its wait state is entered -> states visit 1..8 in order; out_clk_rst falls exactly 4 cycles after entering CLK_RST; done=1, busy=0 in RUN.
- in_clk_locked held 0 -> ERROR 16 cycles after entering CLK_LOCK; error=1, error_code=1; out_clk_rst=1, out_sensor_enable=0.
- in_align_error on every attempt -> clk_dly steps 8,9,10; third failure gives error_code=3, retry_count=3. Second run with CLK_DLY_INIT=31 -> clk_dly wraps to 0.
- in_align_done and in_align_error asserted together -> RETRY, not DPHY; align succeeds on the second attempt -> RUN with retry_count=1, clk_dly=9.
- stop asserted in SENSOR, and start+stop asserted together in IDLE -> IDLE next cycle with all controls in the reset pattern; remains in IDLE.
- reset asserted in DPHY, and start issued in ERROR -> reset gives all reset values next cycle; start from ERROR re-enters CLK_RST with error=0, retry_count=0, clk_dly=8.

Source files
------------

// File: rtl/camera_bringup_sequencer.sv
// camera_bringup_sequencer: ordered power-up and link training for the sensor, LVDS receiver and D-PHY,
// with per-step timeouts and a receiver clock-delay sweep on word-align failure.
module camera_bringup_sequencer #(
    parameter int         TIMER_BITS     = 20,
    parameter int         RST_CYCLES     = 1000,
    parameter int         LOCK_TIMEOUT   = 100000,
    parameter int         SENSOR_TIMEOUT = 500000,
    parameter int         ALIGN_TIMEOUT  = 10000,
    parameter int         DPHY_TIMEOUT   = 100000,
    parameter logic [4:0] CLK_DLY_INIT   = 5'd8,
    parameter logic [4:0] CLK_DLY_STEP   = 5'd1,
    parameter int         MAX_RETRY      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       in_clk_locked,
    input  logic       in_sensor_ready,
    input  logic       in_align_done,
    input  logic       in_align_error,
    input  logic       in_dphy_init_done,
    output logic       out_clk_rst,
    output logic       out_sensor_enable,
    output logic       out_receiver_reset,
    output logic [4:0] out_receiver_clk_dly,
    output logic       out_align_reset,
    output logic       out_dphy_reset,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] error_code,
    output logic [3:0] retry_count,
    output logic [3:0] state
);
    localparam logic [3:0] S_IDLE = 4'd0, S_CLK_RST = 4'd1, S_CLK_LOCK = 4'd2, S_SENSOR = 4'd3,
                           S_RX = 4'd4, S_ALIGN = 4'd5, S_RETRY = 4'd6, S_DPHY = 4'd7,
                           S_RUN = 4'd8, S_ERROR = 4'd9;
    localparam logic [TIMER_BITS-1:0] T_RST    = TIMER_BITS'(RST_CYCLES - 1);
    localparam logic [TIMER_BITS-1:0] T_LOCK   = TIMER_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_BITS-1:0] T_SENSOR = TIMER_BITS'(SENSOR_TIMEOUT - 1);
    localparam logic [TIMER_BITS-1:0] T_ALIGN  = TIMER_BITS'(ALIGN_TIMEOUT - 1);
    localparam logic [TIMER_BITS-1:0] T_DPHY   = TIMER_BITS'(DPHY_TIMEOUT - 1);

    logic [TIMER_BITS-1:0] timer;
    logic [3:0]            state_nxt;
    logic [2:0]            code_nxt;

    always_comb begin
        state_nxt = state;
        code_nxt  = 3'd0;
        if (stop) state_nxt = S_IDLE;
        else case (state)
            S_IDLE, S_ERROR: if (start) state_nxt = S_CLK_RST;
            S_CLK_RST: if (timer == T_RST) state_nxt = S_CLK_LOCK;
            S_CLK_LOCK:
                if (in_clk_locked) state_nxt = S_SENSOR;
                else if (timer == T_LOCK) begin
                    state_nxt = S_ERROR;
                    code_nxt  = 3'd1;
                end
            S_SENSOR:
                if (in_sensor_ready) state_nxt = S_RX;
                else if (timer == T_SENSOR) begin
                    state_nxt = S_ERROR;
                    code_nxt  = 3'd2;
                end
            S_RX: if (timer == T_RST) state_nxt = S_ALIGN;
            // an error flag overrides a simultaneous done
            S_ALIGN:
                if (in_align_error) state_nxt = S_RETRY;
                else if (in_align_done) state_nxt = S_DPHY;
                else if (timer == T_ALIGN) state_nxt = S_RETRY;
            S_RETRY:
                if (retry_count == 4'(MAX_RETRY)) begin
                    state_nxt = S_ERROR;
                    code_nxt  = 3'd3;
                end else if (timer == T_RST) state_nxt = S_RX;
            S_DPHY:
                if (in_dphy_init_done) state_nxt = S_RUN;
                else if (timer == T_DPHY) begin
                    state_nxt = S_ERROR;
                    code_nxt  = 3'd4;
                end
            S_RUN: state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs are registered decodes of the next state so they change on the same edge as state
    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= S_IDLE;
            timer                <= '0;
            out_clk_rst          <= 1'b1;
            out_sensor_enable    <= 1'b0;
            out_receiver_reset   <= 1'b1;
            out_align_reset      <= 1'b1;
            out_dphy_reset       <= 1'b1;
            out_receiver_clk_dly <= CLK_DLY_INIT;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            error                <= 1'b0;
            error_code           <= 3'd0;
            retry_count          <= 4'd0;
        end else begin
            state              <= state_nxt;
            timer              <= (state_nxt != state) ? '0 : timer + TIMER_BITS'(1);
            out_clk_rst        <= state_nxt inside {S_IDLE, S_CLK_RST, S_ERROR};
            out_sensor_enable  <= state_nxt inside {S_SENSOR, S_RX, S_ALIGN, S_RETRY, S_DPHY, S_RUN};
            out_receiver_reset <= !(state_nxt inside {S_RX, S_ALIGN, S_DPHY, S_RUN});
            out_align_reset    <= !(state_nxt inside {S_ALIGN, S_DPHY, S_RUN});
            out_dphy_reset     <= !(state_nxt inside {S_DPHY, S_RUN});
            busy               <= state_nxt >= S_CLK_RST && state_nxt <= S_DPHY;
            done               <= state_nxt == S_RUN;
            error              <= state_nxt == S_ERROR;
            error_code         <= (state_nxt != S_ERROR) ? 3'd0 : (state == S_ERROR) ? error_code : code_nxt;
            if (state_nxt == S_RETRY && state != S_RETRY) begin
                retry_count          <= retry_count + 4'd1;
                out_receiver_clk_dly <= out_receiver_clk_dly + CLK_DLY_STEP;
            end else if (state_nxt == S_IDLE || (state_nxt == S_CLK_RST && state != S_CLK_RST)) begin
                retry_count          <= 4'd0;
                out_receiver_clk_dly <= CLK_DLY_INIT;
            end
        end
    end
endmodule

// File: tb/tb_camera_bringup_sequencer.sv
// tb_camera_bringup_sequencer: directed table of {inputs, hold cycles, expected outputs} plus an align-sweep sequence.
module tb_camera_bringup_sequencer;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
    logic lk = 1'b0, sr = 1'b0, ad = 1'b0, ae = 1'b0, dd = 1'b0;
    logic clk_rst, sen_en, rx_rst, al_rst, dphy_rst, busy, done, error;
    logic [4:0] dly;
    logic [2:0] code;
    logic [3:0] rc, st;
    logic d2_clk_rst, d2_sen_en, d2_rx_rst, d2_al_rst, d2_dphy_rst, d2_busy, d2_done, d2_error;
    logic [4:0] d2_dly;
    logic [2:0] d2_code;
    logic [3:0] d2_rc, d2_st;
    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    camera_bringup_sequencer #(.TIMER_BITS(8), .RST_CYCLES(4), .LOCK_TIMEOUT(16), .SENSOR_TIMEOUT(16),
        .ALIGN_TIMEOUT(16), .DPHY_TIMEOUT(16), .CLK_DLY_INIT(5'd8), .CLK_DLY_STEP(5'd1), .MAX_RETRY(3)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .in_clk_locked(lk), .in_sensor_ready(sr),
        .in_align_done(ad), .in_align_error(ae), .in_dphy_init_done(dd), .out_clk_rst(clk_rst),
        .out_sensor_enable(sen_en), .out_receiver_reset(rx_rst), .out_receiver_clk_dly(dly),
        .out_align_reset(al_rst), .out_dphy_reset(dphy_rst), .busy(busy), .done(done), .error(error),
        .error_code(code), .retry_count(rc), .state(st));

    camera_bringup_sequencer #(.TIMER_BITS(8), .RST_CYCLES(4), .LOCK_TIMEOUT(16), .SENSOR_TIMEOUT(16),
        .ALIGN_TIMEOUT(16), .DPHY_TIMEOUT(16), .CLK_DLY_INIT(5'd31), .CLK_DLY_STEP(5'd1), .MAX_RETRY(3)) dut2 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .in_clk_locked(lk), .in_sensor_ready(sr),
        .in_align_done(ad), .in_align_error(ae), .in_dphy_init_done(dd), .out_clk_rst(d2_clk_rst),
        .out_sensor_enable(d2_sen_en), .out_receiver_reset(d2_rx_rst), .out_receiver_clk_dly(d2_dly),
        .out_align_reset(d2_al_rst), .out_dphy_reset(d2_dphy_rst), .busy(d2_busy), .done(d2_done),
        .error(d2_error), .error_code(d2_code), .retry_count(d2_rc), .state(d2_st));

    typedef struct {
        int         n;
        logic       rst, go, halt;
        logic [4:0] in;
        logic [3:0] st;
        logic [4:0] ctrl;
        logic [4:0] dly;
        logic [2:0] flg, code;
        logic [3:0] rc;
    } vec_t;

    vec_t tbl[49];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    initial begin
        // n, rst, start, stop, {lk,sr,ad,ae,dd}, state, {clk_rst,sen,rx_rst,al_rst,dphy_rst}, dly, {busy,done,error}, code, retry
        tbl[0]  = '{2, 1, 0, 0, 5'b00000, 0, 5'b10111, 8, 3'b000, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 5'b00000, 1, 5'b10111, 8, 3'b100, 0, 0};
        tbl[2]  = '{3, 0, 0, 0, 5'b00000, 1, 5'b10111, 8, 3'b100, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 5'b00000, 2, 5'b00111, 8, 3'b100, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 5'b00000, 2, 5'b00111, 8, 3'b100, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 5'b10000, 3, 5'b01111, 8, 3'b100, 0, 0};
        tbl[6]  = '{1, 0, 0, 0, 5'b10000, 3, 5'b01111, 8, 3'b100, 0, 0};
        tbl[7]  = '{1, 0, 0, 0, 5'b11000, 4, 5'b01011, 8, 3'b100, 0, 0};
        tbl[8]  = '{3, 0, 0, 0, 5'b11000, 4, 5'b01011, 8, 3'b100, 0, 0};
        tbl[9]  = '{1, 0, 0, 0, 5'b11000, 5, 5'b01001, 8, 3'b100, 0, 0};
        tbl[10] = '{1, 0, 0, 0, 5'b11000, 5, 5'b01001, 8, 3'b100, 0, 0};
        tbl[11] = '{1, 0, 0, 0, 5'b11100, 7, 5'b01000, 8, 3'b100, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 5'b11100, 7, 5'b01000, 8, 3'b100, 0, 0};
        tbl[13] = '{1, 0, 0, 0, 5'b11101, 8, 5'b01000, 8, 3'b010, 0, 0};
        tbl[14] = '{3, 0, 0, 0, 5'b00000, 8, 5'b01000, 8, 3'b010, 0, 0};
        tbl[15] = '{1, 0, 0, 1, 5'b00000, 0, 5'b10111, 8, 3'b000, 0, 0};
        tbl[16] = '{1, 0, 1, 0, 5'b00000, 1, 5'b10111, 8, 3'b100, 0, 0};
        tbl[17] = '{4, 0, 0, 0, 5'b00000, 2, 5'b00111, 8, 3'b100, 0, 0};
        tbl[18] = '{15, 0, 0, 0, 5'b00000, 2, 5'b00111, 8, 3'b100, 0, 0};
        tbl[19] = '{1, 0, 0, 0, 5'b00000, 9, 5'b10111, 8, 3'b001, 1, 0};
        tbl[20] = '{3, 0, 0, 0, 5'b00000, 9, 5'b10111, 8, 3'b001, 1, 0};
        tbl[21] = '{1, 0, 1, 0, 5'b00000, 1, 5'b10111, 8, 3'b100, 0, 0};
        tbl[22] = '{4, 0, 0, 0, 5'b11000, 2, 5'b00111, 8, 3'b100, 0, 0};
        tbl[23] = '{1, 0, 0, 0, 5'b11000, 3, 5'b01111, 8, 3'b100, 0, 0};
        tbl[24] = '{1, 0, 0, 0, 5'b11000, 4, 5'b01011, 8, 3'b100, 0, 0};
        tbl[25] = '{4, 0, 0, 0, 5'b11000, 5, 5'b01001, 8, 3'b100, 0, 0};
        tbl[26] = '{1, 0, 0, 0, 5'b11100, 7, 5'b01000, 8, 3'b100, 0, 0};
        tbl[27] = '{1, 1, 0, 0, 5'b11100, 0, 5'b10111, 8, 3'b000, 0, 0};
        tbl[28] = '{1, 0, 0, 0, 5'b00000, 0, 5'b10111, 8, 3'b000, 0, 0};
        tbl[29] = '{1, 0, 1, 1, 5'b00000, 0, 5'b10111, 8, 3'b000, 0, 0};
        tbl[30] = '{2, 0, 0, 0, 5'b00000, 0, 5'b10111, 8, 3'b000, 0, 0};
        tbl[31] = '{1, 0, 1, 0, 5'b00000, 1, 5'b10111, 8, 3'b100, 0, 0};
        tbl[32] = '{4, 0, 0, 0, 5'b00000, 2, 5'b00111, 8, 3'b100, 0, 0};
        tbl[33] = '{1, 0, 0, 0, 5'b10000, 3, 5'b01111, 8, 3'b100, 0, 0};
        tbl[34] = '{1, 0, 0, 1, 5'b10000, 0, 5'b10111, 8, 3'b000, 0, 0};
        tbl[35] = '{2, 0, 0, 0, 5'b00000, 0, 5'b10111, 8, 3'b000, 0, 0};
        tbl[36] = '{1, 0, 1, 0, 5'b11000, 1, 5'b10111, 8, 3'b100, 0, 0};
        tbl[37] = '{4, 0, 0, 0, 5'b11000, 2, 5'b00111, 8, 3'b100, 0, 0};
        tbl[38] = '{1, 0, 0, 0, 5'b11000, 3, 5'b01111, 8, 3'b100, 0, 0};
        tbl[39] = '{1, 0, 0, 0, 5'b11000, 4, 5'b01011, 8, 3'b100, 0, 0};
        tbl[40] = '{4, 0, 0, 0, 5'b11000, 5, 5'b01001, 8, 3'b100, 0, 0};
        tbl[41] = '{1, 0, 0, 0, 5'b11110, 6, 5'b01111, 9, 3'b100, 0, 1};
        tbl[42] = '{3, 0, 0, 0, 5'b11000, 6, 5'b01111, 9, 3'b100, 0, 1};
        tbl[43] = '{1, 0, 0, 0, 5'b11000, 4, 5'b01011, 9, 3'b100, 0, 1};
        tbl[44] = '{4, 0, 0, 0, 5'b11000, 5, 5'b01001, 9, 3'b100, 0, 1};
        tbl[45] = '{1, 0, 0, 0, 5'b11100, 7, 5'b01000, 9, 3'b100, 0, 1};
        tbl[46] = '{1, 0, 0, 0, 5'b11101, 8, 5'b01000, 9, 3'b010, 0, 1};
        tbl[47] = '{1, 0, 0, 1, 5'b00000, 0, 5'b10111, 8, 3'b000, 0, 0};
        tbl[48] = '{1, 0, 0, 0, 5'b00000, 0, 5'b10111, 8, 3'b000, 0, 0};

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            start = tbl[i].go;
            stop  = tbl[i].halt;
            {lk, sr, ad, ae, dd} = tbl[i].in;
            step(tbl[i].n);
            chk($sformatf("row%0d state", i), st, tbl[i].st);
            chk($sformatf("row%0d ctrl", i), {clk_rst, sen_en, rx_rst, al_rst, dphy_rst}, tbl[i].ctrl);
            chk($sformatf("row%0d dly", i), dly, tbl[i].dly);
            chk($sformatf("row%0d flags", i), {busy, done, error}, tbl[i].flg);
            chk($sformatf("row%0d code", i), code, tbl[i].code);
            chk($sformatf("row%0d retry", i), rc, tbl[i].rc);
        end

        // align error on every attempt: delay sweeps 8,9,10 (31,0,1 with the wrapping instance)
        {lk, sr, ad, ae, dd} = 5'b11010;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4 + 1 + 1 + 4);
        chk("sw_align1_state", st, 5);
        chk("sw_align1_dly", dly, 8);
        chk("sw_align1_d2dly", d2_dly, 31);
        step(1);
        chk("sw_retry1_state", st, 6);
        chk("sw_retry1_rc", rc, 1);
        chk("sw_retry1_dly", dly, 9);
        chk("sw_retry1_d2wrap", d2_dly, 0);
        step(8);
        chk("sw_align2_state", st, 5);
        chk("sw_align2_dly", dly, 9);
        step(1);
        chk("sw_retry2_rc", rc, 2);
        chk("sw_retry2_dly", dly, 10);
        chk("sw_retry2_d2dly", d2_dly, 1);
        step(8);
        chk("sw_align3_dly", dly, 10);
        step(1);
        chk("sw_retry3_state", st, 6);
        chk("sw_retry3_rc", rc, 3);
        step(1);
        chk("sw_err_state", st, 9);
        chk("sw_err_code", code, 3);
        chk("sw_err_rc", rc, 3);
        chk("sw_err_flags", {busy, done, error}, 3'b001);
        chk("sw_err_ctrl", {clk_rst, sen_en, rx_rst, al_rst, dphy_rst}, 5'b10111);
        chk("sw_err_dly", dly, 11);
        chk("sw_err_d2dly", d2_dly, 2);
        chk("sw_err_d2state", d2_st, 9);
        chk("sw_err_d2ctrl", {d2_clk_rst, d2_sen_en, d2_rx_rst, d2_al_rst, d2_dphy_rst}, 5'b10111);
        chk("sw_err_d2flags", {d2_busy, d2_done, d2_error}, 3'b001);
        chk("sw_err_d2code", d2_code, 3);
        chk("sw_err_d2rc", d2_rc, 3);

        // restart from ERROR clears status and reloads the delay
        {lk, sr, ad, ae, dd} = 5'b00000;
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("rs_state", st, 1);
        chk("rs_flags", {busy, done, error}, 3'b100);
        chk("rs_code", code, 0);
        chk("rs_rc", rc, 0);
        chk("rs_dly", dly, 8);
        chk("rs_d2dly", d2_dly, 31);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
